// File: rtl/buzzer_tone_sequencer_if.sv
// Buzzer sequencer bus: enable, note push handshake and playback status.
// The master side is the register layer; the slave side is the sequencer.
interface buzzer_tone_sequencer_if #(
    parameter int unsigned HP_WIDTH   = 16,
    parameter int unsigned DUR_WIDTH  = 16,
    parameter int unsigned FIFO_DEPTH = 4
);
    localparam int unsigned LvlWidth = $clog2(FIFO_DEPTH) + 1;

    logic                 ctrl_en;
    logic                 note_valid;
    logic [HP_WIDTH-1:0]  note_half_period;
    logic [DUR_WIDTH-1:0] note_duration;
    logic                 note_ready;
    logic                 buzz;
    logic                 busy;
    logic [LvlWidth-1:0]  queue_level;
    logic                 note_done;

    modport master (
        output ctrl_en, note_valid, note_half_period, note_duration,
        input  note_ready, buzz, busy, queue_level, note_done
    );

    modport slave (
        input  ctrl_en, note_valid, note_half_period, note_duration,
        output note_ready, buzz, busy, queue_level, note_done
    );
endinterface

// File: rtl/buzzer_tone_sequencer.sv
// Buzzer tone sequencer: a small note FIFO feeding a square-wave tone divider
// and a duration timer. Notes play back to back with no gap cycles.
module buzzer_tone_sequencer #(
    parameter int unsigned TICK_DIV   = 50000,
    parameter int unsigned HP_WIDTH   = 16,
    parameter int unsigned DUR_WIDTH  = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input logic clk,
    input logic rst,
    buzzer_tone_sequencer_if.slave bus
);
    localparam int unsigned PtrWidth  = $clog2(FIFO_DEPTH);
    localparam int unsigned LvlWidth  = PtrWidth + 1;
    localparam int unsigned TickWidth = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [TickWidth-1:0] TickReload = TickWidth'(TICK_DIV - 1);
    localparam logic [LvlWidth-1:0]  LvlFull    = LvlWidth'(FIFO_DEPTH);

    typedef enum logic [0:0] {StIdle, StPlay} state_e;

    // Note storage; contents need no reset since the level gates every read.
    logic [HP_WIDTH-1:0]  fifo_hp_q  [FIFO_DEPTH];
    logic [DUR_WIDTH-1:0] fifo_dur_q [FIFO_DEPTH];

    logic [PtrWidth-1:0]  wr_ptr_q, rd_ptr_q;
    logic [LvlWidth-1:0]  level_q, level_d;
    state_e               state_q, state_d;
    logic                 buzz_q, buzz_d;
    logic [HP_WIDTH-1:0]  hp_q, hp_d;
    logic [HP_WIDTH-1:0]  hp_cnt_q, hp_cnt_d;
    logic [TickWidth-1:0] tick_cnt_q, tick_cnt_d;
    logic [DUR_WIDTH-1:0] dur_cnt_q, dur_cnt_d;

    logic                 ready;
    logic                 push;
    logic                 pop;
    logic                 load;
    logic                 note_done;
    logic                 queue_empty;
    logic [HP_WIDTH-1:0]  head_hp;
    logic [DUR_WIDTH-1:0] head_dur;

    assign ready       = bus.ctrl_en && (level_q != LvlFull);
    assign push        = bus.note_valid && ready;
    assign queue_empty = (level_q == '0);
    assign head_hp     = fifo_hp_q[rd_ptr_q];
    assign head_dur    = fifo_dur_q[rd_ptr_q];

    // Play FSM: tone divider, duration timer and loading of the queue head.
    always_comb begin
        state_d    = state_q;
        buzz_d     = buzz_q;
        hp_d       = hp_q;
        hp_cnt_d   = hp_cnt_q;
        tick_cnt_d = tick_cnt_q;
        dur_cnt_d  = dur_cnt_q;
        load       = 1'b0;
        pop        = 1'b0;
        note_done  = 1'b0;

        if (!bus.ctrl_en) begin
            // Abort: silence and idle; the queue is flushed by the pointer logic.
            state_d = StIdle;
            buzz_d  = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    load = !queue_empty;
                end
                StPlay: begin
                    // A rest (half period 0) never toggles, so buzz stays low.
                    if (hp_q != '0) begin
                        if (hp_cnt_q == '0) begin
                            buzz_d   = ~buzz_q;
                            hp_cnt_d = hp_q - HP_WIDTH'(1);
                        end else begin
                            hp_cnt_d = hp_cnt_q - HP_WIDTH'(1);
                        end
                    end
                    if (tick_cnt_q == '0) begin
                        tick_cnt_d = TickReload;
                        dur_cnt_d  = dur_cnt_q - DUR_WIDTH'(1);
                        if (dur_cnt_q == DUR_WIDTH'(1)) begin
                            // Pulse in the last active cycle; next note loads on this edge.
                            note_done = 1'b1;
                            if (!queue_empty) begin
                                load = 1'b1;
                            end else begin
                                buzz_d  = 1'b0;
                                state_d = StIdle;
                            end
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q - TickWidth'(1);
                    end
                end
                default: begin
                    state_d = StIdle;
                    buzz_d  = 1'b0;
                end
            endcase

            if (load) begin
                pop = 1'b1;
                if (head_dur == '0) begin
                    // Zero-length note is dropped; the next entry is seen from IDLE.
                    buzz_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    hp_d       = head_hp;
                    hp_cnt_d   = head_hp - HP_WIDTH'(1);
                    tick_cnt_d = TickReload;
                    dur_cnt_d  = head_dur;
                    buzz_d     = (head_hp != '0);
                    state_d    = StPlay;
                end
            end
        end
    end

    // Queue level: simultaneous push and pop cancel; disable flushes.
    always_comb begin
        level_d = level_q;
        if (!bus.ctrl_en) begin
            level_d = '0;
        end else if (push && !pop) begin
            level_d = level_q + LvlWidth'(1);
        end else if (pop && !push) begin
            level_d = level_q - LvlWidth'(1);
        end
    end

    // State, counters and FIFO pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            buzz_q     <= 1'b0;
            hp_q       <= '0;
            hp_cnt_q   <= '0;
            tick_cnt_q <= '0;
            dur_cnt_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
        end else begin
            state_q    <= state_d;
            buzz_q     <= buzz_d;
            hp_q       <= hp_d;
            hp_cnt_q   <= hp_cnt_d;
            tick_cnt_q <= tick_cnt_d;
            dur_cnt_q  <= dur_cnt_d;
            level_q    <= level_d;
            if (!bus.ctrl_en) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + PtrWidth'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PtrWidth'(1);
                end
            end
        end
    end

    // Note storage write on accepted push.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_hp_q[wr_ptr_q]  <= bus.note_half_period;
            fifo_dur_q[wr_ptr_q] <= bus.note_duration;
        end
    end

    assign bus.note_ready  = ready;
    assign bus.buzz        = buzz_q;
    assign bus.busy        = (state_q == StPlay) || !queue_empty;
    assign bus.queue_level = level_q;
    assign bus.note_done   = note_done;

endmodule

// File: tb/tb_buzzer_tone_sequencer.sv
// Bench for buzzer_tone_sequencer: directed note pushes with hand-written buzz
// patterns, checked by a note_done-driven scoreboard plus direct status checks.
module tb_buzzer_tone_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    buzzer_tone_sequencer_if #(.HP_WIDTH(16), .DUR_WIDTH(16), .FIFO_DEPTH(4)) bus ();

    buzzer_tone_sequencer #(
        .TICK_DIV  (4),
        .HP_WIDTH  (16),
        .DUR_WIDTH (16),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Expected buzz pattern of one note, oldest cycle in the MSB of len bits.
    typedef struct {
        logic [63:0] pat;
        int          len;
        bit          b2b;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fails  = 0;
    logic [63:0] hist     = '0;
    int          since    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at posedge+1; drives one push for a cycle and checks note_ready.
    task automatic push(input int hp, input int dur, input bit exp_acc,
                        input logic [63:0] pat, input int len, input bit b2b);
        exp_t e;
        bus.note_valid       = 1'b1;
        bus.note_half_period = 16'(hp);
        bus.note_duration    = 16'(dur);
        @(negedge clk);
        check("note_ready", bus.note_ready, exp_acc);
        if (exp_acc && dur != 0) begin
            e.pat = pat;
            e.len = len;
            e.b2b = b2b;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.note_valid = 1'b0;
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int max_cycles);
        bit ok = 1'b0;
        for (int i = 0; i < max_cycles && !ok; i++) begin
            @(negedge clk);
            if (!bus.busy && exp_q.size() == 0) ok = 1'b1;
        end
        check("idle_within_budget", ok, 1'b1);
    endtask

    // Monitor: record buzz every cycle; on note_done compare the tail of the trace.
    initial begin
        exp_t        e;
        logic [63:0] mask;
        forever begin
            @(negedge clk);
            hist = {hist[62:0], bus.buzz};
            since++;
            if (bus.note_done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fails++;
                    $display("FAIL unexpected_note_done: got 1 expected 0 at %0t", $time);
                end else begin
                    e    = exp_q.pop_front();
                    mask = (64'd1 << e.len) - 64'd1;
                    check("note_pattern", hist & mask, e.pat);
                    if (e.b2b) check("note_spacing", 64'(since), 64'(e.len));
                end
                since = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ctrl_en          = 1'b0;
        bus.note_valid       = 1'b0;
        bus.note_half_period = '0;
        bus.note_duration    = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_buzz", bus.buzz, 1'b0);
        check("rst_note_done", bus.note_done, 1'b0);
        check("rst_level", bus.queue_level, 0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_ready_disabled", bus.note_ready, 1'b0);
        sync();
        rst         = 1'b0;
        bus.ctrl_en = 1'b1;
        @(negedge clk);
        check("ready_enabled", bus.note_ready, 1'b1);

        // Single note {2,3}
        sync();
        push(2, 3, 1'b1, 64'b110011001100, 12, 1'b0);
        @(negedge clk);
        check("t1_buzz_before_load", bus.buzz, 1'b0);
        check("t1_level_queued", bus.queue_level, 1);
        check("t1_busy_queued", bus.busy, 1'b1);
        @(negedge clk);
        check("t1_buzz_after_load", bus.buzz, 1'b1);
        check("t1_level_loaded", bus.queue_level, 0);
        wait_idle(100);
        check("t1_buzz_idle", bus.buzz, 1'b0);
        check("t1_busy_idle", bus.busy, 1'b0);

        // Back-to-back {2,1} then {1,1}
        sync();
        push(2, 1, 1'b1, 64'b1100, 4, 1'b0);
        push(1, 1, 1'b1, 64'b1010, 4, 1'b1);
        @(negedge clk);
        check("t2_level_one", bus.queue_level, 1);
        repeat (4) @(negedge clk);
        check("t2_level_after_second_load", bus.queue_level, 0);
        check("t2_busy_second", bus.busy, 1'b1);
        wait_idle(100);

        // Rest {0,2} then {3,1}; then a zero-duration note
        sync();
        push(0, 2, 1'b1, 64'b00000000, 8, 1'b0);
        push(3, 1, 1'b1, 64'b1110, 4, 1'b1);
        wait_idle(100);
        sync();
        push(5, 0, 1'b1, 64'b0, 0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("t3_discard_busy", bus.busy, 1'b0);
        check("t3_discard_buzz", bus.buzz, 1'b0);
        check("t3_discard_level", bus.queue_level, 0);
        repeat (4) @(negedge clk);

        // Fill the queue; the sixth push meets a full queue and is dropped
        sync();
        push(2, 2, 1'b1, 64'b11001100, 8, 1'b0);
        push(1, 1, 1'b1, 64'b1010, 4, 1'b1);
        push(3, 1, 1'b1, 64'b1110, 4, 1'b1);
        push(4, 1, 1'b1, 64'b1111, 4, 1'b1);
        push(2, 1, 1'b1, 64'b1100, 4, 1'b1);
        push(1, 2, 1'b0, 64'b0, 0, 1'b0);
        @(negedge clk);
        check("t4_level_full", bus.queue_level, 4);
        check("t4_ready_full", bus.note_ready, 1'b0);
        wait_idle(200);

        // Abort with ctrl_en low for one cycle, two notes queued
        sync();
        push(2, 3, 1'b1, 64'b0, 12, 1'b0);
        push(1, 2, 1'b1, 64'b0, 8, 1'b0);
        push(3, 2, 1'b1, 64'b0, 8, 1'b0);
        bus.ctrl_en          = 1'b0;
        bus.note_valid       = 1'b1;
        bus.note_half_period = 16'd1;
        bus.note_duration    = 16'd1;
        @(negedge clk);
        check("t5_level_before_abort", bus.queue_level, 2);
        check("t5_ready_disabled", bus.note_ready, 1'b0);
        sync();
        exp_q.delete();
        bus.ctrl_en    = 1'b1;
        bus.note_valid = 1'b0;
        @(negedge clk);
        check("t5_abort_buzz", bus.buzz, 1'b0);
        check("t5_abort_level", bus.queue_level, 0);
        check("t5_abort_busy", bus.busy, 1'b0);
        repeat (3) @(negedge clk);
        check("t5_no_late_push", bus.busy, 1'b0);

        // Reset mid-note with three queued, then normal playback
        sync();
        push(2, 3, 1'b1, 64'b0, 12, 1'b0);
        push(1, 2, 1'b1, 64'b0, 8, 1'b0);
        push(3, 2, 1'b1, 64'b0, 8, 1'b0);
        push(2, 2, 1'b1, 64'b0, 8, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("t6_level_before_rst", bus.queue_level, 3);
        sync();
        exp_q.delete();
        rst = 1'b0;
        @(negedge clk);
        check("t6_rst_buzz", bus.buzz, 1'b0);
        check("t6_rst_note_done", bus.note_done, 1'b0);
        check("t6_rst_level", bus.queue_level, 0);
        check("t6_rst_busy", bus.busy, 1'b0);
        sync();
        push(3, 1, 1'b1, 64'b1110, 4, 1'b0);
        wait_idle(100);
        check("t6_final_buzz", bus.buzz, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
